gpr_wr_arb: RTL and testbench

Write-port arbiter and pending-write scoreboard for the general-purpose register file. Two writeback sources share the file's single write port: port A is the single-cycle execute result, port B is the variable-latency load/memory result. The block registers the granted write onto the file's write port (`we_`, `w_addr`, `w_data`). It also keeps a per-register busy bit so decode can stall on registers with an outstanding load.

---
 rtl/gpr_wr_arb.sv | 143 ++++++++++++++
 tb/tb_gpr_wr_arb.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wr_arb.sv
// gpr_wr_arb: arbitrates the register file's single write port between the
// single-cycle execute result (port A) and the variable-latency load result
// (port B), registers the winning write, and tracks which registers still
// have an outstanding load so decode can stall on them.
module gpr_wr_arb #(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int REG_NUM    = 32,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              rsv_valid,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic [ADDR_W-1:0] q_addr0,
   input  logic [ADDR_W-1:0] q_addr1,
   output logic              q_busy0,
   output logic              q_busy1,
   output logic              we_,
   output logic [ADDR_W-1:0] w_addr,
   output logic [DATA_W-1:0] w_data
);

   // Counter just wide enough to hold STARVE_MAX; a zero limit still needs one bit.
   localparam int               CNT_W   = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [REG_NUM-1:0] busy_q, busy_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  w_addr_q, w_addr_d;
   logic [DATA_W-1:0]  w_data_q, w_data_d;

   logic               b_starved;
   logic               grant_a;
   logic               grant_b;

   // Arbitration: A has priority unless B has waited STARVE_MAX cycles; nothing
   // is granted while reset is held so requesters never see a spurious ready.
   always_comb begin
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      b_starved = (wait_cnt_q == CNT_MAX);
      if (reset) begin
         if (a_valid && !(b_valid && b_starved)) begin
            grant_a = 1'b1;
         end else if (b_valid) begin
            grant_b = 1'b1;
         end
      end
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;

   // Starvation counter: counts consecutive cycles B asked and lost, saturating.
   always_comb begin
      wait_cnt_d = '0;
      if (b_valid && !grant_b) begin
         if (wait_cnt_q == CNT_MAX) begin
            wait_cnt_d = wait_cnt_q;
         end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
      end
   end

   // Write-port register: load the winner, otherwise drop we_ and hold the bus.
   always_comb begin
      we_d     = 1'b1;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      if (grant_a) begin
         we_d     = 1'b0;
         w_addr_d = a_addr;
         w_data_d = a_data;
      end else if (grant_b) begin
         we_d     = 1'b0;
         w_addr_d = b_addr;
         w_data_d = b_data;
      end
   end

   // Scoreboard: a B grant clears its register, then a reservation sets its
   // register, so a same-cycle set and clear leaves the new reservation in place.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < REG_NUM; i++) begin
         if (grant_b && (b_addr == ADDR_W'(i))) begin
            busy_d[i] = 1'b0;
         end
      end
      for (int i = 0; i < REG_NUM; i++) begin
         if (rsv_valid && (rsv_addr == ADDR_W'(i))) begin
            busy_d[i] = 1'b1;
         end
      end
   end

   // Decode queries look only at registered state, so a clear shows up the cycle after the grant.
   always_comb begin
      q_busy0 = 1'b0;
      q_busy1 = 1'b0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (q_addr0 == ADDR_W'(i)) begin
            q_busy0 = busy_q[i];
         end
         if (q_addr1 == ADDR_W'(i)) begin
            q_busy1 = busy_q[i];
         end
      end
   end

   // State registers; reset drops any pending write and every reservation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt_q <= '0;
         busy_q     <= '0;
         we_q       <= 1'b1;
         w_addr_q   <= '0;
         w_data_q   <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         busy_q     <= busy_d;
         we_q       <= we_d;
         w_addr_q   <= w_addr_d;
         w_data_q   <= w_data_d;
      end
   end

   assign we_    = we_q;
   assign w_addr = w_addr_q;
   assign w_data = w_data_q;

endmodule

// File: tb/tb_gpr_wr_arb.sv
// tb_gpr_wr_arb: directed walk through reset, single writes, starvation and
// scoreboard corner cases, followed by randomized traffic, all compared against
// a cycle-level behavioural model of the arbiter and scoreboard.
module tb_gpr_wr_arb;

   localparam int ADDR_W     = 5;
   localparam int DATA_W     = 32;
   localparam int REG_NUM    = 32;
   localparam int STARVE_MAX = 3;

   logic              clk;
   logic              reset;
   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              rsv_valid;
   logic [ADDR_W-1:0] rsv_addr;
   logic [ADDR_W-1:0] q_addr0;
   logic [ADDR_W-1:0] q_addr1;
   logic              q_busy0;
   logic              q_busy1;
   logic              we_;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;

   int checks   = 0;
   int failures = 0;

   // Behavioural model state.
   logic [REG_NUM-1:0] m_busy;
   int                 m_wait;
   logic               m_we;
   logic [ADDR_W-1:0]  m_waddr;
   logic [DATA_W-1:0]  m_wdata;
   logic               m_ga;
   logic               m_gb;

   gpr_wr_arb #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .REG_NUM   (REG_NUM),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .a_valid  (a_valid),
      .a_addr   (a_addr),
      .a_data   (a_data),
      .a_ready  (a_ready),
      .b_valid  (b_valid),
      .b_addr   (b_addr),
      .b_data   (b_data),
      .b_ready  (b_ready),
      .rsv_valid(rsv_valid),
      .rsv_addr (rsv_addr),
      .q_addr0  (q_addr0),
      .q_addr1  (q_addr1),
      .q_busy0  (q_busy0),
      .q_busy1  (q_busy1),
      .we_      (we_),
      .w_addr   (w_addr),
      .w_data   (w_data)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_busy  = '0;
      m_wait  = 0;
      m_we    = 1'b1;
      m_waddr = '0;
      m_wdata = '0;
   endtask

   // Who should win this cycle, straight from the arbitration rules.
   task automatic model_grant();
      m_ga = 1'b0;
      m_gb = 1'b0;
      if (reset) begin
         if (a_valid && b_valid) begin
            if (m_wait >= STARVE_MAX) m_gb = 1'b1;
            else                      m_ga = 1'b1;
         end else if (a_valid) begin
            m_ga = 1'b1;
         end else if (b_valid) begin
            m_gb = 1'b1;
         end
      end
   endtask

   task automatic apply_stimulus(input logic av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                                 input logic bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                                 input logic rv, input logic [ADDR_W-1:0] ra);
      a_valid   = av;
      a_addr    = aa;
      a_data    = ad;
      b_valid   = bv;
      b_addr    = ba;
      b_data    = bd;
      rsv_valid = rv;
      rsv_addr  = ra;
   endtask

   // Mid-cycle: compare the combinational outputs with the model.
   task automatic settle_and_check();
      #3;
      model_grant();
      check_output("a_ready", a_ready, m_ga);
      check_output("b_ready", b_ready, m_gb);
      check_output("q_busy0", q_busy0, m_busy[q_addr0]);
      check_output("q_busy1", q_busy1, m_busy[q_addr1]);
   endtask

   // Rising edge: advance the model, then compare the registered write port.
   task automatic clock_edge();
      @(posedge clk);
      if (!reset) begin
         model_reset();
      end else begin
         if (m_ga) begin
            m_we    = 1'b0;
            m_waddr = a_addr;
            m_wdata = a_data;
         end else if (m_gb) begin
            m_we    = 1'b0;
            m_waddr = b_addr;
            m_wdata = b_data;
         end else begin
            m_we = 1'b1;
         end
         if (b_valid && !m_gb) m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : STARVE_MAX;
         else                  m_wait = 0;
         if (m_gb)      m_busy[b_addr]   = 1'b0;
         if (rsv_valid) m_busy[rsv_addr] = 1'b1;
      end
      #1;
      check_output("we_", we_, m_we);
      check_output("w_addr", w_addr, m_waddr);
      check_output("w_data", w_data, m_wdata);
   endtask

   task automatic check_outputs_idle(input string tag);
      check_output({tag, "_we"}, we_, 1'b1);
      check_output({tag, "_waddr"}, w_addr, '0);
      check_output({tag, "_wdata"}, w_data, '0);
   endtask

   // Sweep every register through both query ports while reset is held.
   task automatic check_busy_clear(input string tag);
      for (int i = 0; i < REG_NUM / 2; i++) begin
         q_addr0 = ADDR_W'(2 * i);
         q_addr1 = ADDR_W'(2 * i + 1);
         settle_and_check();
         check_output($sformatf("%s_busy%0d", tag, 2 * i), q_busy0, 1'b0);
         check_output($sformatf("%s_busy%0d", tag, 2 * i + 1), q_busy1, 1'b0);
         check_output({tag, "_a_ready"}, a_ready, 1'b0);
         check_output({tag, "_b_ready"}, b_ready, 1'b0);
         clock_edge();
      end
   endtask

   initial begin
      reset   = 1'b1;
      q_addr0 = '0;
      q_addr1 = '0;
      apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
      model_reset();

      // Reset with both ports requesting.
      #1;
      reset = 1'b0;
      apply_stimulus(1'b1, 5'd1, 32'hAAAA_0001, 1'b1, 5'd2, 32'hBBBB_0002, 1'b0, '0);
      #1;
      check_outputs_idle("rst");
      check_output("rst_a_ready", a_ready, 1'b0);
      check_output("rst_b_ready", b_ready, 1'b0);
      @(posedge clk);
      #1;
      check_busy_clear("rst");

      // Release reset: A wins the first arbitration.
      reset = 1'b1;
      settle_and_check();
      check_output("first_a_ready", a_ready, 1'b1);
      check_output("first_b_ready", b_ready, 1'b0);
      clock_edge();
      check_output("first_waddr", w_addr, 5'd1);

      // Single A write, then an idle cycle.
      apply_stimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, '0, '0, 1'b0, '0);
      settle_and_check();
      check_output("single_a_ready", a_ready, 1'b1);
      clock_edge();
      check_output("single_we", we_, 1'b0);
      check_output("single_waddr", w_addr, 5'd5);
      check_output("single_wdata", w_data, 32'h1234_5678);
      apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
      settle_and_check();
      clock_edge();
      check_output("idle_we", we_, 1'b1);
      check_output("idle_waddr_hold", w_addr, 5'd5);

      // A saturating the port while B waits on register 7.
      for (int c = 0; c < 5; c++) begin
         if (c < 4) apply_stimulus(1'b1, ADDR_W'(c + 1), 32'hA000_0000 + c, 1'b1, 5'd7, 32'hB0B0_0007, 1'b0, '0);
         else       apply_stimulus(1'b1, ADDR_W'(c + 1), 32'hA000_0000 + c, 1'b1, 5'd8, 32'hB0B0_0008, 1'b0, '0);
         settle_and_check();
         check_output($sformatf("starve_a_ready_c%0d", c), a_ready, c != 3);
         check_output($sformatf("starve_b_ready_c%0d", c), b_ready, c == 3);
         clock_edge();
         check_output($sformatf("starve_we_c%0d", c), we_, 1'b0);
         if (c == 3) begin
            check_output("starve_b_waddr", w_addr, 5'd7);
            check_output("starve_b_wdata", w_data, 32'hB0B0_0007);
            check_output("starve_wait_clear", dut.wait_cnt_q, '0);
         end
      end
      apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
      settle_and_check();
      clock_edge();

      // Scoreboard: reserve 9, A write leaves it busy, B write clears it next cycle.
      apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd9);
      settle_and_check();
      clock_edge();
      q_addr0 = 5'd9;
      apply_stimulus(1'b1, 5'd9, 32'h0000_AAA9, 1'b0, '0, '0, 1'b0, '0);
      settle_and_check();
      check_output("sb_busy_after_rsv", q_busy0, 1'b1);
      clock_edge();
      apply_stimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'h0000_BBB9, 1'b0, '0);
      settle_and_check();
      check_output("sb_busy_after_a", q_busy0, 1'b1);
      check_output("sb_b_ready", b_ready, 1'b1);
      clock_edge();
      apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
      settle_and_check();
      check_output("sb_busy_after_b", q_busy0, 1'b0);
      clock_edge();

      // Same-cycle reservation and B clear on register 12: reservation survives.
      q_addr1 = 5'd12;
      apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12);
      settle_and_check();
      clock_edge();
      apply_stimulus(1'b0, '0, '0, 1'b1, 5'd12, 32'h0000_0C0C, 1'b1, 5'd12);
      settle_and_check();
      check_output("setclr_b_ready", b_ready, 1'b1);
      clock_edge();
      apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
      settle_and_check();
      check_output("setclr_busy12", q_busy1, 1'b1);
      clock_edge();

      // Reset the cycle after a B grant to register 3 while 3 and 4 are reserved.
      apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd3);
      settle_and_check();
      clock_edge();
      apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd4);
      settle_and_check();
      clock_edge();
      q_addr0 = 5'd3;
      q_addr1 = 5'd4;
      apply_stimulus(1'b0, '0, '0, 1'b1, 5'd3, 32'hDEAD_0003, 1'b0, '0);
      settle_and_check();
      check_output("mid_busy3", q_busy0, 1'b1);
      check_output("mid_busy4", q_busy1, 1'b1);
      clock_edge();
      check_output("mid_we_pending", we_, 1'b0);
      apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      check_outputs_idle("mid");
      check_output("mid_busy3_clr", q_busy0, 1'b0);
      check_output("mid_busy4_clr", q_busy1, 1'b0);
      check_busy_clear("mid");
      reset = 1'b1;

      // Randomized traffic; requesters hold their request until it is accepted.
      for (int n = 0; n < 400; n++) begin
         if (!a_valid && ($urandom_range(0, 9) < 8)) begin
            a_valid = 1'b1;
            a_addr  = ADDR_W'($urandom);
            a_data  = $urandom;
         end
         if (!b_valid && ($urandom_range(0, 9) < 5)) begin
            b_valid = 1'b1;
            b_addr  = ADDR_W'($urandom);
            b_data  = $urandom;
         end
         rsv_valid = ($urandom_range(0, 3) == 0);
         rsv_addr  = ADDR_W'($urandom);
         q_addr0   = ADDR_W'($urandom);
         q_addr1   = ADDR_W'($urandom);
         settle_and_check();
         clock_edge();
         if (m_ga) a_valid = 1'b0;
         if (m_gb) b_valid = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
